// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests instructions at pc and queues {instruction, pc} for the decoder.
// Define FETCH_SKID_EN for a 2-entry skid queue; the default queue holds a single entry.
module instr_fetch #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_inc,
  input  logic             flush,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             ir_valid,
  input  logic             ir_ready,
  output logic [WIDTH-1:0] ir_data,
  output logic [WIDTH-1:0] ir_pc
);

`ifdef FETCH_SKID_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic [1:0] {IDLE, REQ, STALL} state_t;

  state_t     state;
  logic [1:0] count;
  logic [1:0] next_count;
  logic       push;
  logic       pop;

  // Reset gates the request so an in-flight ack during reset can never complete a fetch.
  assign mem_req  = (state == REQ) & ~reset;
  assign mem_addr = pc;
  assign push     = mem_req & mem_ack & ~flush;
  assign pc_inc   = push;
  assign ir_valid = (count != 2'd0);
  assign pop      = ir_valid & ir_ready & ~flush;

  always_comb begin
    next_count = count;
    if (push && !pop)
      next_count = count + 2'd1;
    else if (pop && !push)
      next_count = count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 2'd0;
    end else if (flush) begin
      state <= IDLE;
      count <= 2'd0;
    end else begin
      count <= next_count;
      case (state)
        IDLE:    state <= REQ;
        REQ:     if (push && !pop && next_count == DEPTH) state <= STALL;
        STALL:   if (pop) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_SKID_EN
  logic [WIDTH-1:0] tail_data;
  logic [WIDTH-1:0] tail_pc;

  // The head register drives ir_data/ir_pc directly; the tail only fills while the head is occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_data   <= '0;
      ir_pc     <= '0;
      tail_data <= '0;
      tail_pc   <= '0;
    end else if (!flush) begin
      if (pop && count == 2'd2) begin
        ir_data <= tail_data;
        ir_pc   <= tail_pc;
      end else if (push && (count == 2'd0 || pop)) begin
        ir_data <= mem_rdata;
        ir_pc   <= pc;
      end
      if (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop))) begin
        tail_data <= mem_rdata;
        tail_pc   <= pc;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_data <= '0;
      ir_pc   <= '0;
    end else if (push) begin
      ir_data <= mem_rdata;
      ir_pc   <= pc;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: the bench owns the PC register and a memory returning addr+0x1000.
// Expectations adapt to the FETCH_SKID_EN build (queue depth 2 vs 1).
module tb_instr_fetch;

`ifdef FETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = 16'd0;
  logic        pc_inc;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic [15:0] target = 16'd0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_inc(pc_inc), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc)
  );

  // Environment: program counter register and instruction memory.
  always @(posedge clk) begin
    if (reset) pc <= 16'd0;
    else if (flush) pc <= target;
    else if (pc_inc) pc <= pc + 16'd1;
  end
  assign mem_rdata = mem_addr + 16'h1000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; flush = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; mem_ack = 1'b1; ir_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (mem_req !== 1'b0 || pc_inc !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs cycle %0d: mem_req=%b pc_inc=%b, want 0 0", i, mem_req, pc_inc);
      end
      tick;
    end
    vectors++;
    if (ir_valid !== 1'b0 || ir_data !== 16'd0 || ir_pc !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_queue: valid=%b data=%h pc=%h, want 0 0000 0000", ir_valid, ir_data, ir_pc);
    end
    reset = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle_cycle: mem_req=%b, want 0", mem_req);
    end
    tick;
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_first_req: mem_req=%b addr=%h, want 1 0000", mem_req, mem_addr);
    end
  endtask

  task automatic test_stream;
    do_reset;
    mem_ack = 1'b1; ir_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (pc_inc !== 1'b1 || mem_addr !== 16'(k)) begin
        miscompares++;
        $display("[TB] FAIL stream_fetch %0d: pc_inc=%b addr=%h, want 1 %h", k, pc_inc, mem_addr, 16'(k));
      end
      tick;
      vectors++;
      if (ir_valid !== 1'b1 || ir_pc !== 16'(k) || ir_data !== 16'(k) + 16'h1000) begin
        miscompares++;
        $display("[TB] FAIL stream_head %0d: valid=%b pc=%h data=%h, want 1 %h %h",
                 k, ir_valid, ir_pc, ir_data, 16'(k), 16'(k) + 16'h1000);
      end
      if (DEPTH == 1) begin
        vectors++;
        if (pc_inc !== 1'b0 || mem_req !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL stream_stall %0d: pc_inc=%b mem_req=%b, want 0 0", k, pc_inc, mem_req);
        end
        tick;
      end
    end
  endtask

  task automatic test_backpressure;
    int incs;
    int pops;
    logic [15:0] popped_pc [3];
    logic [15:0] popped_data [3];
    incs = 0;
    pops = 0;
    do_reset;
    mem_ack = 1'b1; ir_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (pc_inc === 1'b1) incs++;
      tick;
    end
    vectors++;
    if (incs != DEPTH) begin
      miscompares++;
      $display("[TB] FAIL backpressure_completions: got %0d, want %0d", incs, DEPTH);
    end
    vectors++;
    if (mem_req !== 1'b0 || ir_valid !== 1'b1 || ir_pc !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL backpressure_stall: mem_req=%b valid=%b pc=%h, want 0 1 0000", mem_req, ir_valid, ir_pc);
    end
    ir_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ir_valid === 1'b1 && pops < 3) begin
        popped_pc[pops] = ir_pc;
        popped_data[pops] = ir_data;
        pops++;
      end
      tick;
    end
    vectors++;
    if (pops != 3) begin
      miscompares++;
      $display("[TB] FAIL drain_count: got %0d pops, want 3", pops);
    end else begin
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (popped_pc[j] !== 16'(j) || popped_data[j] !== 16'(j) + 16'h1000) begin
          miscompares++;
          $display("[TB] FAIL drain_order %0d: pc=%h data=%h, want %h %h",
                   j, popped_pc[j], popped_data[j], 16'(j), 16'(j) + 16'h1000);
        end
      end
    end
  endtask

  task automatic test_flush;
    do_reset;
    mem_ack = 1'b1; ir_ready = 1'b0;
    tick;
    flush = 1'b1; target = 16'd1997; mem_ack = 1'b1; ir_ready = 1'b1;
    #1;
    vectors++;
    if (pc_inc !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_no_inc: pc_inc=%b, want 0", pc_inc);
    end
    tick;
    flush = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;
    #1;
    vectors++;
    if (ir_valid !== 1'b0 || mem_req !== 1'b0 || ir_pc !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL flush_empty: valid=%b mem_req=%b ir_pc=%h, want 0 0 0000", ir_valid, mem_req, ir_pc);
    end
    tick;
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 16'd1997) begin
      miscompares++;
      $display("[TB] FAIL flush_refetch: mem_req=%b addr=%0d, want 1 1997", mem_req, mem_addr);
    end
  endtask

  task automatic test_reset_flush;
    do_reset;
    mem_ack = 1'b1; ir_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) tick;
    reset = 1'b1; flush = 1'b1; target = 16'd77; ir_ready = 1'b1;
    #1;
    vectors++;
    if (pc_inc !== 1'b0 || mem_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flush_comb: pc_inc=%b mem_req=%b, want 0 0", pc_inc, mem_req);
    end
    tick;
    reset = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    #1;
    vectors++;
    if (ir_valid !== 1'b0 || ir_data !== 16'd0 || ir_pc !== 16'd0 || mem_req !== 1'b0 || pc !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_flush_state: valid=%b data=%h ir_pc=%h mem_req=%b pc=%h, want 0 0000 0000 0 0000",
               ir_valid, ir_data, ir_pc, mem_req, pc);
    end
  endtask

  task automatic test_ack_delay;
    int incs;
    incs = 0;
    do_reset;
    mem_ack = 1'b0; ir_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ack = 1'b1;
      #1;
      if (pc_inc === 1'b1) incs++;
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 16'd0) begin
        miscompares++;
        $display("[TB] FAIL ack_delay_hold %0d: mem_req=%b addr=%h, want 1 0000", i, mem_req, mem_addr);
      end
      tick;
    end
    mem_ack = 1'b0;
    #1;
    vectors++;
    if (incs != 1 || ir_pc !== 16'd0 || ir_data !== 16'h1000 || pc !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL ack_delay_done: incs=%0d ir_pc=%h data=%h pc=%h, want 1 0000 1000 0001",
               incs, ir_pc, ir_data, pc);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_flush;
    test_reset_flush;
    test_ack_delay;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
